// File: rtl/zeroriscy_csr_copy_engine_pkg.sv
// rtl/zeroriscy_csr_copy_engine_pkg.sv - shared constants and types for the CSR copy engine
package zeroriscy_csr_copy_engine_pkg;

    localparam int COPY_N_CSR = 6;
    localparam int COPY_IDX_W = 3;

    // CSR port operation encodings of the zero-riscy core
    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    // CSRs captured in a snapshot, in copy order
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_PCER    = 12'h7A0;
    localparam logic [11:0] CSR_PCMR    = 12'h7A1;
    localparam logic [11:0] CSR_PCCR0   = 12'h780;

    typedef enum logic {
        COPY_SAVE,
        COPY_RESTORE
    } CopyMode_t;

    typedef enum logic [1:0] {
        CP_IDLE,
        CP_ACCESS,
        CP_DONE
    } CopyState_t;

    // Snapshot slot to CSR address; unused slots map to 0 and are never issued
    function automatic logic [11:0] csr_addr_of(input logic [COPY_IDX_W-1:0] idx);
        logic [11:0] addr;
        case (idx)
            3'd0:    addr = CSR_MSTATUS;
            3'd1:    addr = CSR_MEPC;
            3'd2:    addr = CSR_MCAUSE;
            3'd3:    addr = CSR_PCER;
            3'd4:    addr = CSR_PCMR;
            3'd5:    addr = CSR_PCCR0;
            default: addr = 12'h000;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/zeroriscy_csr_copy_engine.sv
// rtl/zeroriscy_csr_copy_engine.sv - saves/restores a fixed CSR list of a halted zero-riscy core
module zeroriscy_csr_copy_engine
    import zeroriscy_csr_copy_engine_pkg::*;
#(
    parameter int N_CSR = COPY_N_CSR,
    parameter int IDX_W = COPY_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             core_halted_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             abort_o,
    output logic             snap_valid_o,
    output logic             csr_access_o,
    output logic [11:0]      csr_addr_o,
    output logic [31:0]      csr_wdata_o,
    output logic [1:0]       csr_op_o,
    input  logic [31:0]      csr_rdata_i,
    input  logic [IDX_W-1:0] buf_idx_i,
    input  logic             buf_we_i,
    input  logic [31:0]      buf_wdata_i,
    output logic [31:0]      buf_rdata_o
);

    localparam logic [IDX_W:0]   N_CSR_W  = (IDX_W+1)'(N_CSR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CSR - 1);

    CopyState_t       state;
    CopyMode_t        mode;
    logic [IDX_W-1:0] idx;
    logic [31:0]      buf_q [N_CSR];
    logic             busy_q;
    logic             done_q;
    logic             abort_q;
    logic             snap_q;

    logic in_access;
    logic access_live;
    logic restore_live;
    logic sys_in_range;

    assign in_access    = (state == CP_ACCESS);
    // Losing halt must release the core's CSR port in the same cycle
    assign access_live  = in_access && core_halted_i;
    assign restore_live = access_live && (mode == COPY_RESTORE);
    assign sys_in_range = ({1'b0, buf_idx_i} < N_CSR_W);

    assign csr_access_o = access_live;
    assign csr_addr_o   = access_live ? csr_addr_of(idx) : 12'h000;
    assign csr_op_o     = restore_live ? CSR_OP_WRITE : CSR_OP_NONE;
    assign csr_wdata_o  = restore_live ? buf_q[idx] : 32'h0;
    assign buf_rdata_o  = sys_in_range ? buf_q[buf_idx_i] : 32'h0;

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign abort_o      = abort_q;
    assign snap_valid_o = snap_q;

    // Copy FSM with index counter, snapshot buffer and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CP_IDLE;
            mode    <= COPY_SAVE;
            idx     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            snap_q  <= 1'b0;
            for (int i = 0; i < N_CSR; i++) begin
                buf_q[i] <= 32'h0;
            end
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                CP_IDLE: begin
                    // System side owns the buffer only while idle; any write spoils the snapshot
                    if (buf_we_i) begin
                        snap_q <= 1'b0;
                        if (sys_in_range) begin
                            buf_q[buf_idx_i] <= buf_wdata_i;
                        end
                    end
                    if (start_i && core_halted_i) begin
                        mode   <= mode_i ? COPY_RESTORE : COPY_SAVE;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= CP_ACCESS;
                    end
                end
                CP_ACCESS: begin
                    if (!core_halted_i) begin
                        state   <= CP_IDLE;
                        idx     <= '0;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b1;
                        snap_q  <= 1'b0;
                    end else begin
                        if (mode == COPY_SAVE) begin
                            buf_q[idx] <= csr_rdata_i;
                        end
                        if (idx == LAST_IDX) begin
                            state  <= CP_DONE;
                            done_q <= 1'b1;
                            if (mode == COPY_SAVE) begin
                                snap_q <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                CP_DONE: begin
                    state  <= CP_IDLE;
                    idx    <= '0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= CP_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zeroriscy_csr_copy_engine.sv
// tb/tb_zeroriscy_csr_copy_engine.sv - scoreboard bench for the CSR copy engine
module tb_zeroriscy_csr_copy_engine;

    localparam int N = 6;
    localparam logic [11:0] ADDR_TAB [N] = '{12'h300, 12'h341, 12'h342, 12'h7A0, 12'h7A1, 12'h780};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        mode_i;
    logic        core_halted_i;
    logic        busy_o;
    logic        done_o;
    logic        abort_o;
    logic        snap_valid_o;
    logic        csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic [31:0] csr_rdata_i;
    logic [2:0]  buf_idx_i;
    logic        buf_we_i;
    logic [31:0] buf_wdata_i;
    logic [31:0] buf_rdata_o;

    always #5 clk = ~clk;

    zeroriscy_csr_copy_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .core_halted_i (core_halted_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .abort_o       (abort_o),
        .snap_valid_o  (snap_valid_o),
        .csr_access_o  (csr_access_o),
        .csr_addr_o    (csr_addr_o),
        .csr_wdata_o   (csr_wdata_o),
        .csr_op_o      (csr_op_o),
        .csr_rdata_i   (csr_rdata_i),
        .buf_idx_i     (buf_idx_i),
        .buf_we_i      (buf_we_i),
        .buf_wdata_i   (buf_wdata_i),
        .buf_rdata_o   (buf_rdata_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
    } acc_t;
    acc_t exp_q[$];

    // Responder core CSRs and the reference model of core and snapshot
    logic [31:0] rsp_csr [N];
    logic [31:0] ref_csr [N];
    logic [31:0] ref_snap [N];
    bit          ref_valid;
    logic        pre_we = 1'b0;
    int          pre_i = 0;
    logic [31:0] pre_v = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder read port: combinational by address
    always_comb begin
        csr_rdata_i = 32'h0;
        for (int i = 0; i < N; i++) begin
            if (csr_addr_o == ADDR_TAB[i]) csr_rdata_i = rsp_csr[i];
        end
    end

    // Responder write port plus bench preset path
    always @(posedge clk) begin
        if (pre_we) rsp_csr[pre_i] <= pre_v;
        if (csr_access_o && csr_op_o == 2'b01) begin
            for (int i = 0; i < N; i++) begin
                if (csr_addr_o == ADDR_TAB[i]) rsp_csr[i] <= csr_wdata_o;
            end
        end
    end

    // Monitor: every CSR access must match the next expected one
    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_access_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got addr %h op %0d, expected none", csr_addr_o, csr_op_o);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    check("acc_addr", {20'h0, csr_addr_o}, {20'h0, e.addr});
                    check("acc_op", {30'h0, csr_op_o}, {30'h0, e.op});
                    check("acc_wdata", csr_wdata_o, e.wdata);
                end
            end else begin
                check("idle_op", {30'h0, csr_op_o}, 32'h0);
            end
        end
    end

    task automatic preset(input int i, input logic [31:0] v);
        pre_we = 1'b1; pre_i = i; pre_v = v;
        @(posedge clk) #1;
        pre_we = 1'b0;
        ref_csr[i] = v;
    endtask

    task automatic sys_write(input int i, input logic [31:0] v);
        buf_we_i = 1'b1; buf_idx_i = 3'(i); buf_wdata_i = v;
        @(posedge clk) #1;
        buf_we_i = 1'b0;
        if (i < N) ref_snap[i] = v;
        ref_valid = 1'b0;
    endtask

    task automatic verify();
        for (int i = 0; i < 8; i++) begin
            buf_idx_i = 3'(i);
            #1;
            check($sformatf("buf_rdata[%0d]", i), buf_rdata_o, (i < N) ? ref_snap[i] : 32'h0);
        end
        for (int i = 0; i < N; i++) check($sformatf("core_csr[%0d]", i), rsp_csr[i], ref_csr[i]);
        check("snap_valid", {31'h0, snap_valid_o}, {31'h0, ref_valid});
        check("exp_q_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // One SAVE/RESTORE; abort_k < N drops halt in that access cycle
    task automatic do_op(input bit m, input int abort_k, input bit noise);
        int k;
        k = (abort_k < N) ? abort_k : N;
        for (int i = 0; i < k; i++) begin
            acc_t e;
            e.addr = ADDR_TAB[i];
            e.op = m ? 2'b01 : 2'b00;
            e.wdata = m ? ref_snap[i] : 32'h0;
            exp_q.push_back(e);
        end
        start_i = 1'b1; mode_i = m; core_halted_i = 1'b1;
        @(posedge clk) #1;
        start_i = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (c == abort_k) begin
                core_halted_i = 1'b0; start_i = 1'b0; buf_we_i = 1'b0;
                @(posedge clk) #1;
                check("abort_pulse", {31'h0, abort_o}, 32'h1);
                check("abort_busy", {31'h0, busy_o}, 32'h0);
                check("abort_done", {31'h0, done_o}, 32'h0);
                core_halted_i = 1'b1;
                @(posedge clk) #1;
                check("abort_once", {31'h0, abort_o}, 32'h0);
                for (int i = 0; i < k; i++) begin
                    if (m) ref_csr[i] = ref_snap[i];
                    else ref_snap[i] = ref_csr[i];
                end
                ref_valid = 1'b0;
                verify();
                return;
            end
            check("busy_access", {31'h0, busy_o}, 32'h1);
            check("no_early_done", {31'h0, done_o}, 32'h0);
            if (noise) begin
                start_i = 1'($urandom);
                buf_we_i = 1'b1;
                buf_idx_i = 3'($urandom_range(0, N - 1));
                buf_wdata_i = $urandom;
            end
            @(posedge clk) #1;
        end
        start_i = 1'b0; buf_we_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m) ref_csr[i] = ref_snap[i];
            else ref_snap[i] = ref_csr[i];
        end
        if (!m) ref_valid = 1'b1;
        check("done_pulse", {31'h0, done_o}, 32'h1);
        check("done_busy", {31'h0, busy_o}, 32'h1);
        check("done_snap_valid", {31'h0, snap_valid_o}, {31'h0, ref_valid});
        @(posedge clk) #1;
        check("done_once", {31'h0, done_o}, 32'h0);
        check("idle_busy", {31'h0, busy_o}, 32'h0);
        verify();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; core_halted_i = 1'b1;
        buf_idx_i = 3'd0; buf_we_i = 1'b0; buf_wdata_i = 32'h0;
        for (int i = 0; i < N; i++) begin
            ref_snap[i] = 32'h0;
        end
        ref_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) preset(i, $urandom);

        // Reset state
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_abort", {31'h0, abort_o}, 32'h0);
        check("rst_access", {31'h0, csr_access_o}, 32'h0);
        check("rst_addr", {20'h0, csr_addr_o}, 32'h0);
        check("rst_wdata", csr_wdata_o, 32'h0);
        verify();

        // SAVE of known values
        preset(0, 32'h0000_1888);
        preset(1, 32'h0000_1234);
        preset(2, 32'h8000_000B);
        do_op(1'b0, N, 1'b0);
        buf_idx_i = 3'd1; #1; check("save_mepc", buf_rdata_o, 32'h0000_1234);
        buf_idx_i = 3'd2; #1; check("save_mcause", buf_rdata_o, 32'h8000_000B);
        buf_idx_i = 3'd0; #1; check("save_mstatus", buf_rdata_o, 32'h0000_1888);

        // RESTORE after system-side edits
        sys_write(1, 32'hDEAD_BEE0);
        sys_write(4, 32'h0000_0001);
        do_op(1'b1, N, 1'b0);
        check("restore_mepc", rsp_csr[1], 32'hDEAD_BEE0);
        check("restore_pcmr", rsp_csr[4], 32'h0000_0001);

        // Abort in the third access cycle of RESTORE
        sys_write(2, 32'h5555_AAAA);
        sys_write(3, 32'h0BAD_0003);
        do_op(1'b1, 2, 1'b0);
        check("abort_mcause_kept", rsp_csr[2], 32'h8000_000B);

        // start/buf_we during busy are ignored
        for (int i = 0; i < N; i++) preset(i, $urandom);
        do_op(1'b0, N, 1'b1);

        // Reset in the middle of SAVE
        for (int i = 0; i < 3; i++) begin
            acc_t e;
            e.addr = ADDR_TAB[i]; e.op = 2'b00; e.wdata = 32'h0;
            exp_q.push_back(e);
        end
        start_i = 1'b1; mode_i = 1'b0; core_halted_i = 1'b1;
        @(posedge clk) #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk) #1;
        rst_n = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b1;
        check("mid_rst_busy", {31'h0, busy_o}, 32'h0);
        check("mid_rst_done", {31'h0, done_o}, 32'h0);
        check("mid_rst_abort", {31'h0, abort_o}, 32'h0);
        check("mid_rst_access", {31'h0, csr_access_o}, 32'h0);
        check("mid_rst_addr", {20'h0, csr_addr_o}, 32'h0);
        check("mid_rst_wdata", csr_wdata_o, 32'h0);
        for (int i = 0; i < N; i++) ref_snap[i] = 32'h0;
        ref_valid = 1'b0;
        verify();

        // start without halt is ignored
        start_i = 1'b1; core_halted_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk) #1;
            check("nohalt_busy", {31'h0, busy_o}, 32'h0);
            check("nohalt_access", {31'h0, csr_access_o}, 32'h0);
        end
        start_i = 1'b0; core_halted_i = 1'b1;
        @(posedge clk) #1;

        // Randomized operations against the reference model
        for (int it = 0; it < 12; it++) begin
            int nw;
            if ($urandom_range(0, 1) == 1) preset($urandom_range(0, N - 1), $urandom);
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) sys_write($urandom_range(0, 7), $urandom);
            do_op(1'($urandom), ($urandom_range(0, 2) == 0) ? $urandom_range(0, N - 1) : N,
                  1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
